// File: rtl/dft_pkg.sv
// Shared definitions for the DFT accumulation scheduler: state encoding,
// default frame geometry and pipeline latencies.
package dft_pkg;

    localparam int N_SAMPLES_DEF  = 128;
    localparam int N_GROUPS_DEF   = 8;
    localparam int MUL_LAT_DEF    = 3;
    localparam int ADD_LAT_DEF    = 4;
    localparam int BINS_PER_GROUP = 16;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        ADD,
        WRITE,
        AMPL_REQ,
        AMPL_WAIT,
        FINISH
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dft_lat_timer.sv
// Loadable down-counter with a zero flag; times the FPMul/FPAdd dwell intervals.
module dft_lat_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (n_reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dft_scheduler.sv
// Frame sequencer for the DFT datapath: walks samples x harmonic groups through
// FPMul/FPAdd, then (with DFT_SCHED_AMPL_EN defined) requests amplitude per bin.
//
//   state     | meaning
//   IDLE      | waiting for start_in
//   MUL       | FPMul enabled for MUL_LAT cycles
//   ADD       | FPAdd enabled for ADD_LAT cycles
//   WRITE     | store the 16 sums, advance sample/group
//   AMPL_REQ  | pulse ampl_start for the current bin
//   AMPL_WAIT | wait for ampl_done
//   FINISH    | pulse done
module dft_scheduler
    import dft_pkg::*;
#(
    parameter int N_SAMPLES = N_SAMPLES_DEF,
    parameter int N_GROUPS  = N_GROUPS_DEF,
    parameter int MUL_LAT   = MUL_LAT_DEF,
    parameter int ADD_LAT   = ADD_LAT_DEF
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       start_in,
    input  logic       abort_in,
    output logic [6:0] time_index,
    output logic [2:0] group_index,
    output logic       mul_en,
    output logic       add_en,
    output logic       acc_zero,
    output logic       acc_we,
    output logic       ampl_start,
    input  logic       ampl_done,
    output logic [6:0] ampl_bin,
    output logic       busy,
    output logic       done
);

    localparam int WAIT_W = $clog2(max_int(MUL_LAT, ADD_LAT) + 1);
    localparam logic [WAIT_W-1:0] MUL_LOAD = WAIT_W'(MUL_LAT - 1);
    localparam logic [WAIT_W-1:0] ADD_LOAD = WAIT_W'(ADD_LAT - 1);
    localparam logic [6:0] TI_LAST = 7'(N_SAMPLES - 1);
    localparam logic [2:0] GI_LAST = 3'(N_GROUPS - 1);
`ifdef DFT_SCHED_AMPL_EN
    localparam logic [6:0] BIN_LAST = 7'(N_GROUPS * BINS_PER_GROUP - 1);
`else
    logic unused_ampl_done;
    assign unused_ampl_done = ampl_done;
`endif

    state_t            state, state_nxt;
    logic [6:0]        ti_nxt, bin_nxt;
    logic [2:0]        gi_nxt;
    logic              timer_load, timer_dec, timer_zero;
    logic [WAIT_W-1:0] timer_val;

    dft_lat_timer #(.W(WAIT_W)) u_lat_timer (
        .clk      (clk),
        .n_reset  (n_reset),
        .load     (timer_load),
        .load_val (timer_val),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (n_reset) begin
            state       <= IDLE;
            time_index  <= '0;
            group_index <= '0;
            ampl_bin    <= '0;
        end else begin
            state       <= state_nxt;
            time_index  <= ti_nxt;
            group_index <= gi_nxt;
            ampl_bin    <= bin_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ti_nxt     = time_index;
        gi_nxt     = group_index;
        bin_nxt    = ampl_bin;
        timer_load = 1'b0;
        timer_val  = MUL_LOAD;
        timer_dec  = 1'b0;
        mul_en     = 1'b0;
        add_en     = 1'b0;
        acc_zero   = 1'b0;
        acc_we     = 1'b0;
        ampl_start = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);

        case (state)
            IDLE: begin
                if (start_in) begin
                    ti_nxt     = '0;
                    gi_nxt     = '0;
                    bin_nxt    = '0;
                    timer_load = 1'b1;
                    timer_val  = MUL_LOAD;
                    state_nxt  = MUL;
                end
            end
            MUL: begin
                mul_en = 1'b1;
                if (timer_zero) begin
                    timer_load = 1'b1;
                    timer_val  = ADD_LOAD;
                    state_nxt  = ADD;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ADD: begin
                add_en   = 1'b1;
                acc_zero = (time_index == '0);
                if (timer_zero) begin
                    state_nxt = WRITE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            WRITE: begin
                acc_we     = 1'b1;
                timer_load = 1'b1;
                timer_val  = MUL_LOAD;
                if (time_index != TI_LAST) begin
                    ti_nxt    = time_index + 7'd1;
                    state_nxt = MUL;
                end else begin
                    ti_nxt = '0;
                    gi_nxt = group_index + 3'd1;
                    if (group_index == GI_LAST) begin
`ifdef DFT_SCHED_AMPL_EN
                        state_nxt = AMPL_REQ;
`else
                        state_nxt = FINISH;
`endif
                    end else begin
                        state_nxt = MUL;
                    end
                end
            end
`ifdef DFT_SCHED_AMPL_EN
            AMPL_REQ: begin
                ampl_start = 1'b1;
                state_nxt  = AMPL_WAIT;
            end
            AMPL_WAIT: begin
                if (ampl_done) begin
                    if (ampl_bin != BIN_LAST) begin
                        bin_nxt   = ampl_bin + 7'd1;
                        state_nxt = AMPL_REQ;
                    end else begin
                        state_nxt = FINISH;
                    end
                end
            end
`endif
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Abort freezes the counters so a coincident ampl_done is dropped.
        if (abort_in && (state != IDLE)) begin
            state_nxt  = IDLE;
            ti_nxt     = time_index;
            gi_nxt     = group_index;
            bin_nxt    = ampl_bin;
            timer_load = 1'b0;
            timer_dec  = 1'b0;
        end
    end

endmodule

// File: tb/tb_dft_scheduler.sv
// Directed bench for dft_scheduler with scoreboard queues for the acc_we
// (group,sample) sequence and the amplitude bin sequence.
module tb_dft_scheduler;

    typedef struct packed {
        logic [2:0] g;
        logic [6:0] t;
    } sample_t;

    logic       clk = 1'b0;
    logic       n_reset = 1'b1;
    logic       start_in = 1'b0;
    logic       abort_in = 1'b0;
    logic       ampl_done_r = 1'b0;
    logic       force_done = 1'b0;
    logic       ampl_done;
    logic [6:0] time_index;
    logic [2:0] group_index;
    logic       mul_en, add_en, acc_zero, acc_we, ampl_start, busy, done;
    logic [6:0] ampl_bin;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wraps = 0;
    int amp_starts = 0;
    bit resp_en = 1'b1;
    logic [6:0] prev_ti = 7'd0;
    sample_t exp_q[$];
    logic [6:0] amp_q[$];

    assign ampl_done = ampl_done_r | force_done;

    dft_scheduler dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .start_in    (start_in),
        .abort_in    (abort_in),
        .time_index  (time_index),
        .group_index (group_index),
        .mul_en      (mul_en),
        .add_en      (add_en),
        .acc_zero    (acc_zero),
        .acc_we      (acc_we),
        .ampl_start  (ampl_start),
        .ampl_done   (ampl_done),
        .ampl_bin    (ampl_bin),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_frame();
        sample_t s;
        for (int g = 0; g < 8; g++) begin
            for (int t = 0; t < 128; t++) begin
                s.g = 3'(g);
                s.t = 7'(t);
                exp_q.push_back(s);
            end
        end
`ifdef DFT_SCHED_AMPL_EN
        for (int b = 0; b < 128; b++) amp_q.push_back(7'(b));
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_time_index"}, time_index, 0);
        chk({tag, "_group_index"}, group_index, 0);
        chk({tag, "_ampl_bin"}, ampl_bin, 0);
        chk({tag, "_enables"}, {mul_en, add_en, acc_zero, acc_we, ampl_start}, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // per-cycle invariants and acc_we scoreboard
    initial begin
        sample_t s;
        forever begin
            @(negedge clk);
            chk("exclusive_enables", 32'($onehot0({mul_en, add_en, acc_we})), 1);
            chk("acc_zero_rule", acc_zero, add_en && (time_index == 7'd0));
`ifndef DFT_SCHED_AMPL_EN
            chk("ampl_start_off", ampl_start, 0);
            chk("ampl_bin_off", ampl_bin, 0);
`endif
            if (acc_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL sb_empty: observed=acc_we expected=no write");
                end else begin
                    s = exp_q.pop_front();
                    chk("sb_group", group_index, s.g);
                    chk("sb_time", time_index, s.t);
                end
            end
            if (prev_ti == 7'd127 && time_index == 7'd0) wraps++;
            prev_ti = time_index;
        end
    end

`ifdef DFT_SCHED_AMPL_EN
    initial begin
        logic [6:0] b;
        forever begin
            @(negedge clk);
            if (ampl_start) begin
                amp_starts++;
                if (amp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL amp_sb_empty: observed=ampl_start expected=none");
                end else begin
                    b = amp_q.pop_front();
                    chk("amp_bin", ampl_bin, b);
                end
                if (resp_en) begin
                    repeat (5) @(negedge clk);
                    ampl_done_r = 1'b1;
                    @(negedge clk);
                    ampl_done_r = 1'b0;
                end
            end
        end
    end
`endif

    initial begin
        int start_cyc;
        int dn;
        logic [6:0] ti_snap;
        logic [2:0] gi_snap;
        int ph;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        n_reset = 1'b0;
        @(negedge clk);

        // full frame with first-sample timing profile
        push_frame();
        wraps = 0;
        amp_starts = 0;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        start_cyc = cyc;
        chk("start_busy", busy, 1);
        chk("start_time_index", time_index, 0);
        for (int i = 0; i < 16; i++) begin
            ph = i % 8;
            chk("prof_mul_en", mul_en, ph < 3);
            chk("prof_add_en", add_en, ph >= 3 && ph < 7);
            chk("prof_acc_we", acc_we, ph == 7);
            chk("prof_acc_zero", acc_zero, (ph >= 3 && ph < 7) && i < 8);
            @(negedge clk);
        end
        for (int i = 0; i < 20000 && !done; i++) @(negedge clk);
        chk("frame_done", done, 1);
`ifndef DFT_SCHED_AMPL_EN
        chk("frame_latency", cyc - start_cyc, 8192);
`else
        chk("ampl_pulses", amp_starts, 128);
        chk("amp_queue_drained", amp_q.size(), 0);
`endif
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after_frame", busy, 0);
        chk("time_wraps", wraps, 8);
        chk("queue_drained", exp_q.size(), 0);

        // start while busy, then abort at group 3 sample 50 during ADD
        push_frame();
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        for (int i = 0; i < 200 && !(mul_en && time_index == 7'd5); i++) @(negedge clk);
        chk("reach_sample5", mul_en && time_index == 7'd5, 1);
        ti_snap = time_index;
        gi_snap = group_index;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        chk("busy_start_ti", time_index, ti_snap);
        chk("busy_start_gi", group_index, gi_snap);
        chk("busy_start_busy", busy, 1);
        for (int i = 0; i < 5000 && !(add_en && group_index == 3'd3 && time_index == 7'd50); i++)
            @(negedge clk);
        chk("reach_abort_point", add_en && group_index == 3'd3 && time_index == 7'd50, 1);
        dn = 0;
        abort_in = 1'b1;
        @(negedge clk);
        abort_in = 1'b0;
        if (done) dn++;
        chk("abort_busy", busy, 0);
        chk("abort_enables", {mul_en, add_en, acc_zero, acc_we, ampl_start}, 0);
        chk("abort_done", done, 0);
        exp_q.delete();
        amp_q.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", dn, 0);
        chk("abort_stays_idle", busy, 0);

        // restart, then reset mid-frame with competing inputs
        push_frame();
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        chk("restart_ti", time_index, 0);
        chk("restart_gi", group_index, 0);
        chk("restart_mul", mul_en, 1);
`ifdef DFT_SCHED_AMPL_EN
        resp_en = 1'b0;
        for (int i = 0; i < 10000 && !ampl_start; i++) @(negedge clk);
        chk("reach_ampl", ampl_start, 1);
        repeat (2) @(negedge clk);
`else
        repeat (100) @(negedge clk);
`endif
        n_reset = 1'b1;
        force_done = 1'b1;
        abort_in = 1'b1;
        start_in = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        force_done = 1'b0;
        abort_in = 1'b0;
        start_in = 1'b0;
        @(negedge clk);
        n_reset = 1'b0;
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("midreset_no_done", dn, 0);
        chk("midreset_idle", busy, 0);
        exp_q.delete();
        amp_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dft_scheduler.md
DFT_SCHEDULER -- requirements
Module: dft_scheduler

Interface
REQ-001 SHALL have parameters: N_SAMPLES, default 128, samples per frame; N_GROUPS, default 8, harmonic groups of 16 bins; MUL_LAT, default 3, FPMul pipeline depth in enabled cycles; ADD_LAT, default 4, FPAdd pipeline depth in enabled cycles.
REQ-002 SHALL use one clock, clk; reset n_reset SHALL be synchronous and active-high.
REQ-003 SHALL have ports: clk  in  1  clock; n_reset  in  1  sync active-high reset; start_in  in  1  frame start request; abort_in  in  1  cancel the current frame.
REQ-004 SHALL have ports: time_index  out  7  sample address to the time buffer; group_index  out  3  harmonic group under accumulation; mul_en  out  1  FPMul clock enable; add_en  out  1  FPAdd clock enable; acc_zero  out  1  forces FPAdd term2 to 0.
REQ-005 SHALL have ports: acc_we  out  1  write the 16 sums to the accumulators and the result RAM; ampl_start  out  1  amplitude-unit start pulse; ampl_done  in  1  amplitude-unit done; ampl_bin  out  7  bin index to the amplitude unit; busy  out  1  frame in progress; done  out  1  one-cycle frame-complete pulse.

Function
REQ-006 SHALL implement the states IDLE, MUL, ADD, WRITE, AMPL_REQ, AMPL_WAIT and FINISH, using a wait counter of width clog2(max(MUL_LAT,ADD_LAT)+1).
REQ-007 IDLE: when start_in=1, SHALL clear time_index and group_index and go to MUL; start_in SHALL be ignored in every other state.
REQ-008 MUL: SHALL hold mul_en=1 for exactly MUL_LAT cycles, then go to ADD.
REQ-009 ADD: SHALL hold add_en=1 for exactly ADD_LAT cycles, then go to WRITE; acc_zero SHALL equal (time_index==0) for the whole ADD state.
REQ-010 WRITE: SHALL assert acc_we for one cycle.
REQ-011 On leaving WRITE with time_index<N_SAMPLES-1, time_index SHALL increment and the state SHALL go to MUL.
REQ-012 On leaving WRITE with time_index==N_SAMPLES-1, time_index SHALL wrap to 0 and group_index SHALL increment.
REQ-013 At that wrap, if group_index==N_GROUPS-1, the next state SHALL be AMPL_REQ (FINISH when the amplitude phase is compiled out).
REQ-014 One sample SHALL take MUL_LAT+ADD_LAT+1 cycles; one frame SHALL take N_SAMPLES*N_GROUPS*(MUL_LAT+ADD_LAT+1) cycles before the amplitude phase.
REQ-015 mul_en, add_en and acc_we SHALL be mutually exclusive in every cycle.
REQ-016 AMPL_REQ: SHALL pulse ampl_start for one cycle with ampl_bin valid, then go to AMPL_WAIT.
REQ-017 AMPL_WAIT: on ampl_done=1, if ampl_bin<N_GROUPS*16-1, SHALL increment ampl_bin and go to AMPL_REQ, otherwise go to FINISH; ampl_done outside AMPL_WAIT SHALL be ignored.
REQ-018 FINISH: SHALL pulse done for one cycle and return to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 abort_in=1 in any non-IDLE state SHALL force IDLE on the next edge, with all enables deasserted and no done pulse; abort_in SHALL take priority over every other transition, and a simultaneous ampl_done SHALL be discarded.

Reset
REQ-021 n_reset=1 SHALL set state IDLE, counters 0 and all outputs 0 (time_index, group_index, ampl_bin, mul_en, add_en, acc_zero, acc_we, ampl_start, busy, done).
REQ-022 Reset asserted mid-frame SHALL take precedence over abort_in and start_in, and SHALL produce no done pulse.

Configuration
REQ-023 With DFT_SCHED_AMPL_EN defined, the block SHALL include the AMPL_REQ and AMPL_WAIT states and the ampl_* ports.
REQ-024 With DFT_SCHED_AMPL_EN undefined, the block SHALL go from the last WRITE directly to FINISH, hold ampl_start and ampl_bin at 0, and ignore ampl_done.

Structure
REQ-025 A shared package dft_pkg SHALL hold the state enum, the default N_SAMPLES, N_GROUPS, MUL_LAT and ADD_LAT, and BINS_PER_GROUP=16.
REQ-026 One sub-module, dft_lat_timer (a loadable down-counter with a zero flag), SHALL generate the MUL and ADD dwell intervals.

Verification
REQ-027 Defaults, start_in pulse: the first sample SHALL show mul_en high for 3 cycles, then add_en high for 4 cycles with acc_zero=1, then acc_we for 1 cycle; the second sample SHALL run with acc_zero=0.
REQ-028 Full frame, ampl compiled out: done SHALL pulse exactly 8192 cycles after start (128*8*8); group_index SHALL step 0..7 and time_index SHALL wrap 127->0 eight times.
REQ-029 Ampl compiled in, ampl_done returned 5 cycles after each ampl_start: exactly 128 ampl_start pulses SHALL occur with ampl_bin 0..127, followed by one done pulse.
REQ-030 abort_in at group 3, sample 50, during ADD: the next cycle SHALL show IDLE, busy=0, all enables 0 and no done; a new start_in SHALL restart from time_index 0, group_index 0.
REQ-031 n_reset asserted mid AMPL_WAIT together with ampl_done: all outputs SHALL be 0 on the next cycle; start_in asserted while busy SHALL not change any counter.
